// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package seq_mult_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_mult_abs.sv
// Combinational magnitude and sign of a two's-complement operand.
// The magnitude is unsigned WIDTH bits, so the most negative value maps cleanly.
module seq_mult_abs #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] mag,
   output logic             neg
);

   // magnitude select
   always_comb begin
      neg = x[WIDTH-1];
      if (x[WIDTH-1]) begin
         mag = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         mag = x;
      end
   end

endmodule

// File: rtl/seq_mult_hs.sv
// Fixed-latency shift-add multiplier with start/busy/done handshake.
// Optional signed mode is enabled by defining SEQ_MULT_SIGNED_EN.
module seq_mult_hs
   import seq_mult_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
`ifdef SEQ_MULT_SIGNED_EN
   input  logic               sign_mode,
`endif
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] C
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t               state_r;
   state_t               state_nx_s;
   logic                 accept_s;
   logic [2*WIDTH-1:0]   mcand_r;
   logic [WIDTH-1:0]     mult_r;
   logic [2*WIDTH-1:0]   acc_r;
   logic [CNT_W-1:0]     cnt_r;
   logic [2*WIDTH-1:0]   c_r;
   logic [2*WIDTH-1:0]   acc_sum_s;
   logic [2*WIDTH-1:0]   result_s;
   logic [WIDTH-1:0]     a_op_s;
   logic [WIDTH-1:0]     b_op_s;

`ifdef SEQ_MULT_SIGNED_EN
   logic [WIDTH-1:0]     a_mag_s;
   logic [WIDTH-1:0]     b_mag_s;
   logic                 a_neg_s;
   logic                 b_neg_s;
   logic                 neg_in_s;
   logic                 neg_r;

   seq_mult_abs #(.WIDTH(WIDTH)) u_abs_a (.x(A), .mag(a_mag_s), .neg(a_neg_s));
   seq_mult_abs #(.WIDTH(WIDTH)) u_abs_b (.x(B), .mag(b_mag_s), .neg(b_neg_s));

   // operand conditioning: multiply magnitudes, fix the sign at the end
   always_comb begin
      a_op_s   = A;
      b_op_s   = B;
      neg_in_s = 1'b0;
      if (sign_mode) begin
         a_op_s   = a_mag_s;
         b_op_s   = b_mag_s;
         neg_in_s = a_neg_s ^ b_neg_s;
      end else begin
         neg_in_s = 1'b0;
      end
   end

   assign result_s = neg_r ? (~acc_sum_s + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_sum_s;
`else
   assign a_op_s   = A;
   assign b_op_s   = B;
   assign result_s = acc_sum_s;
`endif

   // accumulator value after the current iteration, used for the final write too
   assign acc_sum_s = acc_r + (mult_r[0] ? mcand_r : {(2*WIDTH){1'b0}});

   // next-state and accept decode
   always_comb begin
      state_nx_s = state_r;
      accept_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nx_s = ST_RUN;
               accept_s   = 1'b1;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (cnt_r == CNT_LAST) begin
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_RUN;
            end
         end
         ST_DONE: begin
            if (start) begin
               state_nx_s = ST_RUN;
               accept_s   = 1'b1;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // state, iteration datapath and held product
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         mcand_r <= {(2*WIDTH){1'b0}};
         mult_r  <= {WIDTH{1'b0}};
         acc_r   <= {(2*WIDTH){1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
         c_r     <= {(2*WIDTH){1'b0}};
`ifdef SEQ_MULT_SIGNED_EN
         neg_r   <= 1'b0;
`endif
      end else begin
         state_r <= state_nx_s;
         if (accept_s) begin
            mcand_r <= {{WIDTH{1'b0}}, a_op_s};
            mult_r  <= b_op_s;
            acc_r   <= {(2*WIDTH){1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
`ifdef SEQ_MULT_SIGNED_EN
            neg_r   <= neg_in_s;
`endif
         end else if (state_r == ST_RUN) begin
            acc_r   <= acc_sum_s;
            mcand_r <= mcand_r << 1;
            mult_r  <= mult_r >> 1;
            cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_r == CNT_LAST) begin
               c_r <= result_s;
            end
         end
      end
   end

   assign busy = (state_r == ST_RUN);
   assign done = (state_r == ST_DONE);
   assign C    = c_r;

endmodule

// File: tb/tb_seq_mult_hs.sv
// Randomised self-checking bench for seq_mult_hs against an arithmetic reference.
module tb_seq_mult_hs;

   localparam int W   = 8;
   localparam int LAT = W;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [W-1:0]   A = '0;
   logic [W-1:0]   B = '0;
   logic           sign_mode_v = 1'b0;
   logic           busy;
   logic           done;
   logic [2*W-1:0] C;

   int checks = 0;
   int failures = 0;

   seq_mult_hs #(.WIDTH(W)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .A(A),
      .B(B),
`ifdef SEQ_MULT_SIGNED_EN
      .sign_mode(sign_mode_v),
`endif
      .busy(busy),
      .done(done),
      .C(C)
   );

   always #5 clk = ~clk;

   // reference product straight from integer arithmetic
   function automatic logic [2*W-1:0] exp_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic sm);
      longint sa, sb, p;
      logic   use_signed;
      use_signed = sm;
`ifndef SEQ_MULT_SIGNED_EN
      use_signed = 1'b0;
`endif
      if (use_signed) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'(a);
         sb = longint'(b);
      end
      p = sa * sb;
      return p[2*W-1:0];
   endfunction

   // issue one op with a one-cycle start; report product, latency and busy samples
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                        output logic [2*W-1:0] c_got, output int lat, output int busy_cnt);
      @(negedge clk);
      A = a; B = b; sign_mode_v = sm; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0; busy_cnt = 0;
      while (!done && lat < 40) begin
         if (busy) busy_cnt++;
         @(posedge clk); #1;
         lat++;
      end
      c_got = C;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (C !== '0) begin failures++; $display("FAIL reset_c got=%h exp=0", C); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [2*W-1:0] c_got;
      int lat, bc;
      logic [W-1:0] av [3] = '{8'd239, 8'd255, 8'd0};
      logic [W-1:0] bv [3] = '{8'd163, 8'd255, 8'd200};
      logic [2*W-1:0] ev [3] = '{16'd38957, 16'hFE01, 16'h0000};
      for (int i = 0; i < 3; i++) begin
         do_op(av[i], bv[i], 1'b0, c_got, lat, bc);
         checks++; if (c_got !== ev[i]) begin failures++; $display("FAIL dir_c[%0d] got=%h exp=%h", i, c_got, ev[i]); end
         checks++; if (lat != LAT) begin failures++; $display("FAIL dir_lat[%0d] got=%0d exp=%0d", i, lat, LAT); end
         checks++; if (bc != LAT) begin failures++; $display("FAIL dir_busy[%0d] got=%0d exp=%0d", i, bc, LAT); end
         @(posedge clk); #1;
         checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL dir_pulse[%0d] got done=%b busy=%b exp 0/0", i, done, busy); end
         checks++; if (C !== ev[i]) begin failures++; $display("FAIL dir_hold[%0d] got=%h exp=%h", i, C, ev[i]); end
      end
   endtask

   task automatic test_random();
      logic [2*W-1:0] c_got, e;
      int lat, bc;
      logic [W-1:0] a, b;
      for (int i = 0; i < 20; i++) begin
         a = W'($urandom); b = W'($urandom);
         e = exp_prod(a, b, 1'b0);
         do_op(a, b, 1'b0, c_got, lat, bc);
         checks++; if (c_got !== e || lat != LAT) begin failures++; $display("FAIL rand[%0d] %0d*%0d got=%h lat=%0d exp=%h lat=%0d", i, a, b, c_got, lat, e, LAT); end
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] a1, b1, a2, b2;
      int lat;
      a1 = W'($urandom); b1 = W'($urandom);
      a2 = W'($urandom); b2 = W'($urandom);
      @(negedge clk);
      A = a1; B = b1; sign_mode_v = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      lat = 0;
      while (!done && lat < 40) begin
         if (lat == 3) begin A = a2; B = b2; end
         @(posedge clk); #1;
         lat++;
      end
      checks++; if (lat != LAT) begin failures++; $display("FAIL b2b_lat1 got=%0d exp=%0d", lat, LAT); end
      checks++; if (C !== exp_prod(a1, b1, 1'b0)) begin failures++; $display("FAIL b2b_c1 got=%h exp=%h", C, exp_prod(a1, b1, 1'b0)); end
      @(posedge clk); #1;
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL b2b_restart got busy=%b done=%b exp 1/0", busy, done); end
      lat = 0;
      while (!done && lat < 40) begin
         if (lat == 2) begin A = W'($urandom); B = W'($urandom); start = 1'b0; end
         if (lat == 4) start = 1'b1;
         if (lat == 5) start = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      checks++; if (lat != LAT) begin failures++; $display("FAIL b2b_lat2 got=%0d exp=%0d", lat, LAT); end
      checks++; if (C !== exp_prod(a2, b2, 1'b0)) begin failures++; $display("FAIL b2b_c2 got=%h exp=%h", C, exp_prod(a2, b2, 1'b0)); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got done=%b busy=%b exp 0/0", done, busy); end
   endtask

`ifdef SEQ_MULT_SIGNED_EN
   task automatic test_signed();
      logic [2*W-1:0] c_got, e;
      int lat, bc;
      logic [W-1:0] a, b;
      logic sm;
      logic [W-1:0] av [3] = '{8'hEF, 8'h80, 8'h80};
      logic [W-1:0] bv [3] = '{8'hA3, 8'h80, 8'h01};
      logic [2*W-1:0] ev [3] = '{16'h062D, 16'h4000, 16'hFF80};
      for (int i = 0; i < 3; i++) begin
         do_op(av[i], bv[i], 1'b1, c_got, lat, bc);
         checks++; if (c_got !== ev[i] || lat != LAT) begin failures++; $display("FAIL sdir[%0d] got=%h lat=%0d exp=%h lat=%0d", i, c_got, lat, ev[i], LAT); end
      end
      for (int i = 0; i < 16; i++) begin
         a = W'($urandom); b = W'($urandom); sm = 1'($urandom);
         e = exp_prod(a, b, sm);
         do_op(a, b, sm, c_got, lat, bc);
         checks++; if (c_got !== e || lat != LAT) begin failures++; $display("FAIL srand[%0d] sm=%b %h*%h got=%h exp=%h", i, sm, a, b, c_got, e); end
      end
   endtask
`endif

   task automatic test_mid_reset();
      logic [2*W-1:0] c_got, e;
      int lat, bc, seen;
      logic [W-1:0] a, b;
      @(negedge clk);
      A = 8'd201; B = 8'd77; sign_mode_v = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL mrst_ctl got busy=%b done=%b exp 0/0", busy, done); end
      checks++; if (C !== '0) begin failures++; $display("FAIL mrst_c got=%h exp=0", C); end
      @(negedge clk); rst_n = 1'b1;
      seen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      checks++; if (seen != 0) begin failures++; $display("FAIL mrst_nodone got=%0d pulses exp=0", seen); end
      a = W'($urandom); b = W'($urandom);
      e = exp_prod(a, b, 1'b0);
      do_op(a, b, 1'b0, c_got, lat, bc);
      checks++; if (c_got !== e || lat != LAT) begin failures++; $display("FAIL mrst_after got=%h lat=%0d exp=%h lat=%0d", c_got, lat, e, LAT); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
`ifdef SEQ_MULT_SIGNED_EN
      test_signed();
`endif
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
